// File: rtl/if_id_reg.sv
// IF/ID pipeline register: carries the fetched PC, instruction word and fetch
// exception code into decode, with stall, flush and branch-delay-slot tracking.
module if_id_reg #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [4:0]  EXC_ADEL  = 5'd4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  input  logic [4:0]  exc_f,
  input  logic        br_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic [31:0] instr_d,
  output logic [4:0]  exc_d,
  output logic        bd_d,
  output logic        valid_d
);

  logic fault;

  assign fault = (exc_f != 5'd0);

  // F -> D boundary: reset beats flush beats load; otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_d    <= RESET_PC;
      instr_d <= NOP_INSTR;
      exc_d   <= 5'd0;
      bd_d    <= 1'b0;
      valid_d <= 1'b0;
    end else if (flush) begin
      pc_d    <= pc_f;
      instr_d <= NOP_INSTR;
      exc_d   <= 5'd0;
      bd_d    <= 1'b0;
      valid_d <= 1'b0;
    end else if (en) begin
      pc_d    <= pc_f;
      instr_d <= fault ? NOP_INSTR : instr_f;
      exc_d   <= exc_f;
      bd_d    <= br_d;
      valid_d <= 1'b1;
    end
  end

  assign pc8_d = pc_d + 32'd8;

  // Fetch only ever reports an address error, so any other code is an upstream bug.
  a_exc_code : assert property (@(posedge clk) disable iff (reset)
    (exc_f == 5'd0) || (exc_f == EXC_ADEL));

endmodule

// File: tb/tb_if_id_reg.sv
// Randomized self-checking bench for if_id_reg against an abstract model of
// the decode-stage contents (directed scenarios first, then random traffic).
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        reset, en, flush, br_d;
  logic [31:0] pc_f, instr_f;
  logic [4:0]  exc_f;
  logic [31:0] pc_d, pc8_d, instr_d;
  logic [4:0]  exc_d;
  logic        bd_d, valid_d;

  int tests = 0;
  int fails = 0;

  // expected decode-stage contents
  logic [31:0] m_pc, m_instr;
  logic [4:0]  m_exc;
  logic        m_bd, m_valid;

  if_id_reg dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .pc_f(pc_f), .instr_f(instr_f), .exc_f(exc_f), .br_d(br_d),
    .pc_d(pc_d), .pc8_d(pc8_d), .instr_d(instr_d), .exc_d(exc_d),
    .bd_d(bd_d), .valid_d(valid_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: what decode should hold after one edge with the given inputs.
  task automatic model_edge(input logic r, input logic f, input logic e,
                            input logic [31:0] pc, input logic [31:0] ins,
                            input logic [4:0] ex, input logic br);
    if (r) begin
      m_pc = 32'h3000; m_instr = 32'h0; m_exc = 5'd0; m_bd = 1'b0; m_valid = 1'b0;
    end else if (f) begin
      m_pc = pc; m_instr = 32'h0; m_exc = 5'd0; m_bd = 1'b0; m_valid = 1'b0;
    end else if (e) begin
      m_pc    = pc;
      m_valid = 1'b1;
      m_bd    = br;
      m_exc   = ex;
      m_instr = (ex != 5'd0) ? 32'h0 : ins;
    end
  endtask

  task automatic cyc(input logic r, input logic f, input logic e,
                     input logic [31:0] pc, input logic [31:0] ins,
                     input logic [4:0] ex, input logic br);
    reset = r; flush = f; en = e; pc_f = pc; instr_f = ins; exc_f = ex; br_d = br;
    @(posedge clk);
    #1;
    model_edge(r, f, e, pc, ins, ex, br);
    check("pc_d",    pc_d,            m_pc);
    check("pc8_d",   pc8_d,           m_pc + 32'd8);
    check("instr_d", instr_d,         m_instr);
    check("exc_d",   {27'd0, exc_d},  {27'd0, m_exc});
    check("bd_d",    {31'd0, bd_d},   {31'd0, m_bd});
    check("valid_d", {31'd0, valid_d},{31'd0, m_valid});
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; flush = 1'b0; br_d = 1'b0;
    pc_f = 32'h0; instr_f = 32'h0; exc_f = 5'd0;

    // reset held two cycles
    cyc(1, 0, 1, 32'h1234_5678, 32'hDEAD_BEEF, 5'd0, 1);
    cyc(1, 0, 0, 32'h0000_0040, 32'h1111_1111, 5'd0, 0);
    check("rst_pc8_const", pc8_d, 32'h0000_3008);

    // streaming
    cyc(0, 0, 1, 32'h3000, 32'h3C01_0001, 5'd0, 0);
    check("stream_instr0", instr_d, 32'h3C01_0001);
    cyc(0, 0, 1, 32'h3004, 32'h3421_0002, 5'd0, 0);
    // stall three cycles while fetch moves on
    cyc(0, 0, 0, 32'h3008, 32'h0, 5'd0, 1);
    cyc(0, 0, 0, 32'h300C, 32'hAAAA_AAAA, 5'd0, 0);
    cyc(0, 0, 0, 32'h3010, 32'hBBBB_BBBB, 5'd0, 1);
    check("stall_pc_const", pc_d, 32'h3004);
    cyc(0, 0, 1, 32'h3008, 32'h0, 5'd0, 0);

    // delay slot marking, then held across a stall
    cyc(0, 0, 1, 32'h3010, 32'h0000_0001, 5'd0, 1);
    check("bd_set_const", {31'd0, bd_d}, 32'd1);
    cyc(0, 0, 1, 32'h3014, 32'h0000_0002, 5'd0, 0);
    cyc(0, 0, 1, 32'h3018, 32'h0000_0003, 5'd0, 1);
    cyc(0, 0, 0, 32'h301C, 32'h0000_0004, 5'd0, 0);
    cyc(0, 0, 0, 32'h301C, 32'h0000_0004, 5'd0, 0);
    check("bd_hold_const", {31'd0, bd_d}, 32'd1);

    // fetch faults
    cyc(0, 0, 1, 32'h3002, 32'hFFFF_FFFF, 5'd4, 0);
    check("fault_instr_const", instr_d, 32'h0);
    cyc(0, 0, 1, 32'h5000, 32'h1234_5678, 5'd4, 1);

    // flush beats stall; reset beats flush; back-to-back flushes
    cyc(0, 1, 0, 32'h4180, 32'h5555_5555, 5'd0, 1);
    check("flush_pc_const", pc_d, 32'h4180);
    cyc(0, 1, 1, 32'h4184, 32'h6666_6666, 5'd4, 1);
    cyc(1, 1, 1, 32'h4188, 32'h7777_7777, 5'd0, 1);
    cyc(0, 0, 0, 32'h4190, 32'h8888_8888, 5'd0, 0);
    check("post_rst_valid_const", {31'd0, valid_d}, 32'd0);

    // pc8 wrap-around
    cyc(0, 0, 1, 32'hFFFF_FFF8, 32'h0000_0009, 5'd0, 0);
    check("pc8_wrap_const", pc8_d, 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 29) == 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 + ($urandom_range(0, 1) * 4)
                                       : $urandom,
          $urandom,
          ($urandom_range(0, 4) == 0) ? 5'd4 : 5'd0,
          $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
